fetch_port_arbiter: RTL

FETCH_PORT_ARBITER -- requirements
Module: fetch_port_arbiter

---
 rtl/fetch_port_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_port_arbiter
//  Description : Shares one in-order memory port between the instruction
//                fetch unit and an auxiliary (debug/prefetch) requester.
//                Requests are granted combinationally with a 1-bit
//                round-robin pointer. Every issued request leaves an owner
//                tag in an in-order FIFO so that responses can be routed
//                back. A flush kills fetch-owned tags so their responses
//                are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_port_arbiter #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
)(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFLUSH,
    // fetch requester
    input  logic        iFETCH_REQ,
    input  logic [1:0]  iFETCH_MMUMOD,
    input  logic [31:0] iFETCH_ADDR,
    output logic        oFETCH_LOCK,
    output logic        oFETCH_VALID,
    output logic        oFETCH_PAGEFAULT,
    output logic [13:0] oFETCH_MMU_FLAGS,
    output logic [31:0] oFETCH_INST,
    // auxiliary requester
    input  logic        iAUX_REQ,
    input  logic [1:0]  iAUX_MMUMOD,
    input  logic [31:0] iAUX_ADDR,
    output logic        oAUX_LOCK,
    output logic        oAUX_VALID,
    output logic        oAUX_PAGEFAULT,
    output logic [31:0] oAUX_DATA,
    // memory port
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic        iMEM_PAGEFAULT,
    input  logic [13:0] iMEM_MMU_FLAGS,
    input  logic [31:0] iMEM_DATA,
    // status
    output logic        oERROR
);

    // Occupancy value meaning "every tag slot is in use".
    localparam logic [P_DEPTH_N:0] c_FULL_COUNT  = (P_DEPTH_N + 1)'(P_DEPTH);
    // Owner tag encoding stored in the FIFO.
    localparam logic               c_OWNER_FETCH = 1'b0;
    localparam logic               c_OWNER_AUX   = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [P_DEPTH-1:0]   r_owner;        // owner tag per FIFO slot
    logic [P_DEPTH-1:0]   r_killed;       // response for this slot is discarded
    logic [P_DEPTH_N-1:0] r_wrPtr;
    logic [P_DEPTH_N-1:0] r_rdPtr;
    logic [P_DEPTH_N:0]   r_count;        // outstanding request count
    logic                 r_rrPtr;        // 0 = fetch has priority, 1 = aux
    logic                 r_error;

    logic                 r_fetchValid;
    logic                 r_fetchPageFault;
    logic [13:0]          r_fetchMmuFlags;
    logic [31:0]          r_fetchInst;
    logic                 r_auxValid;
    logic                 r_auxPageFault;
    logic [31:0]          r_auxData;

    // ------------------------------------------------------------------
    // Combinational arbitration and FIFO control
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_headOwner;
    logic w_headKilled;
    logic w_fetchElig;
    logic w_auxElig;
    logic w_bothReq;
    logic w_grantFetch;
    logic w_memReq;
    logic w_issue;
    logic w_deliverFetch;
    logic w_deliverAux;

    // Grant selection, issue detection and response routing for this cycle.
    always_comb begin
        w_empty      = (r_count == '0);
        w_full       = (r_count == c_FULL_COUNT);
        w_pop        = iMEM_VALID && !w_empty;
        w_headOwner  = r_owner[r_rdPtr];
        w_headKilled = r_killed[r_rdPtr];

        // Combinational requests are gated by reset so that every output
        // reads zero while inRESET is low. A flush masks the fetch side only.
        w_fetchElig  = inRESET && iFETCH_REQ && !iFLUSH;
        w_auxElig    = inRESET && iAUX_REQ;
        w_bothReq    = w_fetchElig && w_auxElig;

        // Fetch wins when it is alone, or when both ask and it holds priority.
        w_grantFetch = w_fetchElig && (!w_auxElig || (r_rrPtr == 1'b0));

        // A full FIFO still grants if a slot is being freed this same cycle.
        w_memReq     = (w_fetchElig || w_auxElig) && (!w_full || w_pop);
        w_issue      = w_memReq && !iMEM_LOCK;

        // A fetch response popped during a flush is dropped as well.
        w_deliverFetch = w_pop && (w_headOwner == c_OWNER_FETCH) &&
                         !w_headKilled && !iFLUSH;
        w_deliverAux   = w_pop && (w_headOwner == c_OWNER_AUX) && !w_headKilled;
    end

    // Memory-port request side: mirror the granted requester.
    always_comb begin
        oMEM_REQ    = w_memReq;
        oMEM_ADDR   = '0;
        oMEM_MMUMOD = '0;
        if (w_memReq) begin
            oMEM_ADDR   = w_grantFetch ? iFETCH_ADDR   : iAUX_ADDR;
            oMEM_MMUMOD = w_grantFetch ? iFETCH_MMUMOD : iAUX_MMUMOD;
        end
        // A requester is locked whenever it asks and is not the one issuing.
        oFETCH_LOCK = inRESET && iFETCH_REQ && !(w_issue &&  w_grantFetch);
        oAUX_LOCK   = inRESET && iAUX_REQ   && !(w_issue && !w_grantFetch);
    end

    // ------------------------------------------------------------------
    // Tag FIFO: push owner on issue, pop head on response, kill on flush
    // ------------------------------------------------------------------
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_owner  <= '0;
            r_killed <= '0;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
        end else begin
            // Killing every fetch-owned slot is safe: slots outside the live
            // window are rewritten with killed=0 when they are next pushed.
            // A fetch push never coincides with a flush since fetch is masked.
            if (iFLUSH) begin
                r_killed <= r_killed | ~r_owner;
            end
            if (w_issue) begin
                r_owner[r_wrPtr]  <= w_grantFetch ? c_OWNER_FETCH : c_OWNER_AUX;
                r_killed[r_wrPtr] <= 1'b0;
                r_wrPtr           <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + {{P_DEPTH_N{1'b0}}, w_issue}
                               - {{P_DEPTH_N{1'b0}}, w_pop};
        end
    end

    // Round-robin pointer: hand priority to the loser after a contested issue.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_rrPtr <= 1'b0;
        end else if (w_issue && w_bothReq) begin
            r_rrPtr <= w_grantFetch;
        end
    end

    // Registered fetch response: one-cycle VALID pulse, payload held otherwise.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_fetchValid     <= 1'b0;
            r_fetchPageFault <= 1'b0;
            r_fetchMmuFlags  <= '0;
            r_fetchInst      <= '0;
        end else begin
            r_fetchValid <= w_deliverFetch;
            if (w_deliverFetch) begin
                r_fetchPageFault <= iMEM_PAGEFAULT;
                r_fetchMmuFlags  <= iMEM_MMU_FLAGS;
                r_fetchInst      <= iMEM_DATA;
            end
        end
    end

    // Registered aux response: one-cycle VALID pulse, payload held otherwise.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_auxValid     <= 1'b0;
            r_auxPageFault <= 1'b0;
            r_auxData      <= '0;
        end else begin
            r_auxValid <= w_deliverAux;
            if (w_deliverAux) begin
                r_auxPageFault <= iMEM_PAGEFAULT;
                r_auxData      <= iMEM_DATA;
            end
        end
    end

    // Sticky error: a response arrived while nothing was outstanding.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_error <= 1'b0;
        end else if (iMEM_VALID && w_empty) begin
            r_error <= 1'b1;
        end
    end

    assign oFETCH_VALID     = r_fetchValid;
    assign oFETCH_PAGEFAULT = r_fetchPageFault;
    assign oFETCH_MMU_FLAGS = r_fetchMmuFlags;
    assign oFETCH_INST      = r_fetchInst;
    assign oAUX_VALID       = r_auxValid;
    assign oAUX_PAGEFAULT   = r_auxPageFault;
    assign oAUX_DATA        = r_auxData;
    assign oERROR           = r_error;

endmodule
`default_nettype wire
